ika2151_dac_receiver: RTL and testbench
=======================================

Name: ika2151_dac_receiver

Overview:
- Receiving end of the sound chip's serial DAC link: consumes SO, SH1 and SH2 from the core, the same interface a YM3012-style DAC sees.
- Deserializes 16-bit floating-point frames.
- Converts each frame to 16-bit signed linear PCM and presents left (SH1) and right (SH2) samples with strobes.
- Checks frame timing and reports sync lock and frame errors.
- Sits beside the timing generator, clocked by the same emulator master clock and phi1 negative-edge enable.

Parameters:
- ZERO_EXP_MUTE, 1: 1 = exponent 0 decodes to 0; 0 = exponent 0 decodes identically to exponent 1.

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_IC_n  in  1  reset; one clock; asynchronous, active-low
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active-low; all state except reset advances only when low
- i_SO  in  1  serial sample data, LSB first
- i_SH1  in  1  left-channel sample-hold strobe, active-high
- i_SH2  in  1  right-channel sample-hold strobe, active-high
- i_ERR_CLR  in  1  synchronous clear of o_FRAME_ERR, sampled on enable
- o_L  out  16  left sample, signed
- o_R  out  16  right sample, signed
- o_L_VALID  out  1  one-EMUCLK pulse on o_L update
- o_R_VALID  out  1  one-EMUCLK pulse on o_R update
- o_SAMPLE_STROBE  out  1  one-EMUCLK pulse when a complete L then R pair has updated
- o_LOCKED  out  1  frame timing in sync
- o_FRAME_ERR  out  1  sticky frame error

Behaviour:
- Reset (i_IC_n low, asynchronous) clears the following to 0 immediately:
  - all outputs
  - shift register sr[15:0], sh1_d, sh2_d
  - bit counter cnt[4:0], expected-channel flag exp_r, pair flag
- Enable cycle = EMUCLK edge with i_phi1_NCEN_n low. On each enable:
  - sr <= {i_SO, sr[15:1]}
  - sh1_d <= i_SH1; sh2_d <= i_SH2
- Falling edge of SHx at an enable means shx_d = 1 and i_SHx = 0.
- Frame decode uses sr as it was before this enable's shift (the last 16 bits):
  - bits 2:0 ignored
  - bits 12:3 = mantissa D[9:0]
  - bits 15:13 = exponent E[2:0]
  - signed mantissa m = {~D9, D[8:0]} as 10-bit two's complement (equals D-512)
  - E = 1..7: out = sign-extend(m) <<< (E-1), 16 bits, no overflow possible (max 0x7FC0, min 0x8000)
  - E = 0: out = 0 if ZERO_EXP_MUTE, else as E = 1
- Edge event processing, at the enable where the edge is detected:
  - Both SH1 and SH2 fall at once: error, no latch, o_LOCKED <= 0, cnt <= 0.
  - Single edge while o_LOCKED = 0:
    - accept: latch the channel, o_LOCKED <= 1, cnt <= 0
    - exp_r <= 1 after SH1, 0 after SH2
    - no error check
  - Single edge while o_LOCKED = 1: valid only if cnt == 15 and channel matches exp_r (SH1 expected when exp_r = 0).
    - Valid: latch, cnt <= 0, toggle exp_r.
    - Invalid: no latch, o_FRAME_ERR <= 1, o_LOCKED <= 0, cnt <= 0.
- Non-edge enable: cnt <= cnt + 1, saturating at 31.
- Latch timing: o_L or o_R takes the decoded value at the edge enable; the matching VALID pulse is high for exactly the next EMUCLK cycle.
- o_SAMPLE_STROBE:
  - pair flag set on an accepted SH1 latch
  - on an accepted SH2 latch with pair flag set: pulse o_SAMPLE_STROBE aligned with o_R_VALID, then clear the flag
  - any error clears the pair flag
- o_FRAME_ERR stays set until an enable with i_ERR_CLR = 1. If an error and a clear occur at the same enable, the error wins.
- Outputs hold their last value while unlocked.
- Reset mid-frame discards any partial frame; the first edge after reset re-locks without an error.

Test Plan:
- Reset, SH1 pulse then SH2 pulse spaced 16 enables, frame D=0x3FF E=7 (LSB-first stream 000,1111111111,111) -> o_L = 0x7FC0, o_L_VALID pulses once, o_LOCKED = 1.
- Locked, SH2 frame D=0x000 E=7 -> o_R = 0x8000, o_R_VALID and o_SAMPLE_STROBE pulse together.
- D=0x2FF E=3 -> out = 0x00FF<<2 = 0x03FC. D=0x200 E=5 -> 0x0000. D=0x1FF E=0 with ZERO_EXP_MUTE=1 -> 0x0000; with 0 -> 0xFFFF.
- Locked, SH2 falls 15 enables after SH1 -> o_FRAME_ERR = 1, o_LOCKED = 0, o_R unchanged. Next edge re-locks. i_ERR_CLR = 1 on an enable -> o_FRAME_ERR = 0.
- SH1 and SH2 fall on the same enable -> no latch, error set. Two consecutive SH1 edges 16 enables apart while locked -> error.
- Assert i_IC_n low mid-frame with no enable active -> all outputs 0 immediately. Release, resume 16-enable cadence -> first edge accepted silently, o_FRAME_ERR stays 0.

Source files
------------

// File: rtl/ika2151_dac_receiver.sv
// Receiving end of the serial DAC link: deserializes 16-bit floating-point
// frames from SO/SH1/SH2, converts them to signed linear PCM and tracks frame lock.
module ika2151_dac_receiver #(
    parameter bit ZERO_EXP_MUTE = 1'b1
) (
    input  logic        i_EMUCLK,
    input  logic        i_IC_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_SO,
    input  logic        i_SH1,
    input  logic        i_SH2,
    input  logic        i_ERR_CLR,
    output logic [15:0] o_L,
    output logic [15:0] o_R,
    output logic        o_L_VALID,
    output logic        o_R_VALID,
    output logic        o_SAMPLE_STROBE,
    output logic        o_LOCKED,
    output logic        o_FRAME_ERR
);

    // state       | meaning
    // ST_UNLOCKED | no frame timing; next single SHx edge is accepted and locks
    // ST_EXP_L    | locked, next frame must end with an SH1 edge 16 enables later
    // ST_EXP_R    | locked, next frame must end with an SH2 edge 16 enables later
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_EXP_L    = 2'd1,
        ST_EXP_R    = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic        en;
    logic [15:0] sr;
    logic        sh1_d, sh2_d;
    logic [4:0]  cnt;
    logic        pair;
    logic        fall1, fall2, edge_any;
    logic        accept_l, accept_r, err;
    logic [2:0]  exp_f;
    logic [9:0]  mant;
    logic [15:0] mant_ext;
    logic [2:0]  shamt;
    logic [15:0] dec;
    logic        unused_sr_lsbs;

    assign en       = ~i_phi1_NCEN_n;
    assign fall1    = en & sh1_d & ~i_SH1;
    assign fall2    = en & sh2_d & ~i_SH2;
    assign edge_any = fall1 | fall2;
    assign o_LOCKED = (state != ST_UNLOCKED);

    // The three oldest bits of a frame carry no information.
    assign unused_sr_lsbs = ^sr[2:0];

    // Decode the frame currently held in sr (the 16 bits before this enable).
    always_comb begin
        exp_f    = sr[15:13];
        mant     = {~sr[12], sr[11:3]};
        mant_ext = {{6{mant[9]}}, mant};
        shamt    = (exp_f == 3'd0) ? 3'd0 : exp_f - 3'd1;
        dec      = mant_ext << shamt;
        if (ZERO_EXP_MUTE && (exp_f == 3'd0)) begin
            dec = 16'h0000;
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            state <= ST_UNLOCKED;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept_l = 1'b0;
        accept_r = 1'b0;
        err      = 1'b0;
        if (fall1 && fall2) begin
            err      = 1'b1;
            state_nx = ST_UNLOCKED;
        end else if (edge_any) begin
            case (state)
                ST_UNLOCKED: begin
                    accept_l = fall1;
                    accept_r = fall2;
                    state_nx = fall1 ? ST_EXP_R : ST_EXP_L;
                end
                ST_EXP_L: begin
                    if (fall1 && (cnt == 5'd15)) begin
                        accept_l = 1'b1;
                        state_nx = ST_EXP_R;
                    end else begin
                        err      = 1'b1;
                        state_nx = ST_UNLOCKED;
                    end
                end
                ST_EXP_R: begin
                    if (fall2 && (cnt == 5'd15)) begin
                        accept_r = 1'b1;
                        state_nx = ST_EXP_L;
                    end else begin
                        err      = 1'b1;
                        state_nx = ST_UNLOCKED;
                    end
                end
                default: state_nx = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_IC_n) begin
        if (!i_IC_n) begin
            sr              <= 16'h0000;
            sh1_d           <= 1'b0;
            sh2_d           <= 1'b0;
            cnt             <= 5'd0;
            pair            <= 1'b0;
            o_L             <= 16'h0000;
            o_R             <= 16'h0000;
            o_L_VALID       <= 1'b0;
            o_R_VALID       <= 1'b0;
            o_SAMPLE_STROBE <= 1'b0;
            o_FRAME_ERR     <= 1'b0;
        end else begin
            // Strobes are derived from en-gated edges, so they last one EMUCLK.
            o_L_VALID       <= accept_l;
            o_R_VALID       <= accept_r;
            o_SAMPLE_STROBE <= accept_r & pair;

            if (en) begin
                sr    <= {i_SO, sr[15:1]};
                sh1_d <= i_SH1;
                sh2_d <= i_SH2;
                if (edge_any) begin
                    cnt <= 5'd0;
                end else if (cnt != 5'd31) begin
                    cnt <= cnt + 5'd1;
                end
            end

            if (accept_l) begin
                o_L <= dec;
            end
            if (accept_r) begin
                o_R <= dec;
            end

            if (err) begin
                pair <= 1'b0;
            end else if (accept_l) begin
                pair <= 1'b1;
            end else if (accept_r) begin
                pair <= 1'b0;
            end

            if (err) begin
                o_FRAME_ERR <= 1'b1;
            end else if (en && i_ERR_CLR) begin
                o_FRAME_ERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ika2151_dac_receiver.sv
// Bench for ika2151_dac_receiver: directed frames plus random frame streams,
// checked every clock against a frame-level reference model (both mute settings).
module tb_ika2151_dac_receiver;

    logic        clk = 1'b0;
    logic        ic_n, ncen_n, so, sh1, sh2, clr;
    logic [15:0] l1, r1, l0, r0;
    logic        lv1, rv1, ss1, lk1, fe1;
    logic        lv0, rv0, ss0, lk0, fe0;

    always #5 clk = ~clk;

    ika2151_dac_receiver #(.ZERO_EXP_MUTE(1'b1)) u_dut (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen_n), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(clr),
        .o_L(l1), .o_R(r1), .o_L_VALID(lv1), .o_R_VALID(rv1),
        .o_SAMPLE_STROBE(ss1), .o_LOCKED(lk1), .o_FRAME_ERR(fe1)
    );

    ika2151_dac_receiver #(.ZERO_EXP_MUTE(1'b0)) u_dut_nomute (
        .i_EMUCLK(clk), .i_IC_n(ic_n), .i_phi1_NCEN_n(ncen_n), .i_SO(so),
        .i_SH1(sh1), .i_SH2(sh2), .i_ERR_CLR(clr),
        .o_L(l0), .o_R(r0), .o_L_VALID(lv0), .o_R_VALID(rv0),
        .o_SAMPLE_STROBE(ss0), .o_LOCKED(lk0), .o_FRAME_ERR(fe0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_lv1  = 0;
    int cnt_ss1  = 0;
    int g_gap    = 0;

    // reference model state
    bit          hist[$];
    bit          m_locked, m_exp_r, m_pair, m_err, m_sh1_d, m_sh2_d;
    bit          m_lv, m_rv, m_ss;
    int          m_since;
    logic [15:0] m_l1, m_r1, m_l0, m_r0;

    task automatic check_eq(string tag, logic [15:0] got, logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_decode(logic [15:0] f, bit mute);
        int e, d, v;
        e = int'(f[15:13]);
        d = int'(f[12:3]);
        if (e == 0) begin
            if (mute) return 16'h0000;
            e = 1;
        end
        v = (d - 512) * (1 << (e - 1));
        return v[15:0];
    endfunction

    function automatic logic [15:0] mk(logic [9:0] d, logic [2:0] e);
        return {e, d, 3'($urandom)};
    endfunction

    task automatic model_reset();
        hist = {};
        repeat (16) hist.push_back(1'b0);
        m_locked = 0; m_exp_r = 0; m_pair = 0; m_err = 0;
        m_sh1_d = 0; m_sh2_d = 0; m_lv = 0; m_rv = 0; m_ss = 0;
        m_since = 0;
        m_l1 = '0; m_r1 = '0; m_l0 = '0; m_r0 = '0;
    endtask

    task automatic model_step();
        bit f1, f2, e, is_r;
        logic [15:0] fr;
        m_lv = 0; m_rv = 0; m_ss = 0;
        if (!ncen_n) begin
            f1 = m_sh1_d && !sh1;
            f2 = m_sh2_d && !sh2;
            e  = 0;
            for (int i = 0; i < 16; i++) fr[i] = hist[i];
            if (f1 && f2) begin
                e = 1;
            end else if (f1 || f2) begin
                is_r = f2;
                if (!m_locked || (m_since == 15 && is_r == m_exp_r)) begin
                    if (is_r) begin
                        m_r1 = ref_decode(fr, 1'b1);
                        m_r0 = ref_decode(fr, 1'b0);
                        m_rv = 1;
                        m_ss = m_pair;
                        m_pair = 0;
                    end else begin
                        m_l1 = ref_decode(fr, 1'b1);
                        m_l0 = ref_decode(fr, 1'b0);
                        m_lv = 1;
                        m_pair = 1;
                    end
                    m_locked = 1;
                    m_exp_r = !is_r;
                end else begin
                    e = 1;
                end
            end
            if (f1 || f2) m_since = 0;
            else if (m_since < 31) m_since++;
            if (e) begin
                m_err = 1; m_locked = 0; m_pair = 0;
            end else if (clr) begin
                m_err = 0;
            end
            hist.push_back(so);
            void'(hist.pop_front());
            m_sh1_d = sh1;
            m_sh2_d = sh2;
        end
    endtask

    task automatic compare_all();
        check_eq("o_L",      l1,  m_l1);
        check_eq("o_R",      r1,  m_r1);
        check_eq("o_L_VALID", lv1, m_lv);
        check_eq("o_R_VALID", rv1, m_rv);
        check_eq("o_SAMPLE_STROBE", ss1, m_ss);
        check_eq("o_LOCKED", lk1, m_locked);
        check_eq("o_FRAME_ERR", fe1, m_err);
        check_eq("nomute_o_L", l0, m_l0);
        check_eq("nomute_o_R", r0, m_r0);
        check_eq("nomute_strobes", {lv0, rv0, ss0, lk0, fe0},
                 {m_lv, m_rv, m_ss, m_locked, m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        if (lv1) cnt_lv1++;
        if (ss1) cnt_ss1++;
    endtask

    task automatic enable_cycle(bit b_so, bit b_sh1, bit b_sh2, bit b_clr);
        repeat ($urandom_range(g_gap, 0)) begin
            ncen_n = 1'b1;
            so  = 1'($urandom);
            sh1 = 1'($urandom);
            sh2 = 1'($urandom);
            clr = 1'($urandom);
            tick();
        end
        ncen_n = 1'b0;
        so = b_so; sh1 = b_sh1; sh2 = b_sh2; clr = b_clr;
        tick();
    endtask

    // ch: bit0 = SH1, bit1 = SH2 held high on the last of n enables
    task automatic send_frame(logic [15:0] f, int ch, int n, bit clr0);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = (i < 16) ? f[i] : 1'($urandom);
            enable_cycle(b, (ch & 1) != 0 && i == n - 1,
                         (ch & 2) != 0 && i == n - 1, clr0 && i == 0);
        end
    endtask

    initial begin
        int nxt, ch, n, lv_before;
        ic_n = 1'b0; ncen_n = 1'b1; so = 0; sh1 = 0; sh2 = 0; clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        ic_n = 1'b1;

        send_frame(mk(10'h3FF, 3'd7), 1, 16, 0);
        send_frame(mk(10'h000, 3'd7), 2, 16, 0);
        check_eq("first_l_7fc0", l1, 16'h7FC0);
        check_eq("first_locked", lk1, 1'b1);
        check_eq("first_lvalid_count", 16'(cnt_lv1), 16'd1);
        send_frame(mk(10'h2FF, 3'd3), 1, 16, 0);
        check_eq("r_8000", r1, 16'h8000);
        check_eq("pair_strobe_count", 16'(cnt_ss1), 16'd1);
        send_frame(mk(10'h200, 3'd5), 2, 16, 0);
        check_eq("l_03fc", l1, 16'h03FC);
        send_frame(mk(10'h1FF, 3'd0), 1, 16, 0);
        check_eq("r_zero_mant", r1, 16'h0000);
        send_frame(mk(10'h1FF, 3'd0), 2, 16, 0);
        check_eq("l_exp0_mute", l1, 16'h0000);
        check_eq("l_exp0_nomute", l0, 16'hFFFF);
        send_frame(16'($urandom), 1, 16, 0);
        check_eq("r_exp0_nomute", r0, 16'hFFFF);

        // SH2 edge 15 enables after SH1
        send_frame(16'($urandom), 2, 15, 0);
        send_frame(16'($urandom), 1, 16, 0);
        check_eq("short_err", fe1, 1'b1);
        check_eq("short_unlocked", lk1, 1'b0);
        check_eq("short_r_held", r0, 16'hFFFF);
        send_frame(16'($urandom), 2, 16, 0);
        check_eq("relock", lk1, 1'b1);
        check_eq("err_sticky", fe1, 1'b1);
        send_frame(16'($urandom), 1, 16, 1);
        check_eq("err_cleared", fe1, 1'b0);

        // both strobes fall together
        send_frame(16'($urandom), 3, 16, 0);
        lv_before = cnt_lv1;
        send_frame(16'($urandom), 1, 16, 0);
        check_eq("both_err", fe1, 1'b1);
        check_eq("both_no_latch", 16'(cnt_lv1 - lv_before), 16'd0);
        // relock on SH1 with clear, then a second SH1 while SH2 is expected
        send_frame(16'($urandom), 1, 16, 1);
        check_eq("relock_clear", fe1, 1'b0);
        send_frame(16'($urandom), 2, 16, 0);
        check_eq("double_sh1_err", fe1, 1'b1);

        // asynchronous reset mid-frame, between enables
        send_frame(16'($urandom), 0, 7, 0);
        ncen_n = 1'b1;
        #2;
        ic_n = 1'b0;
        #1;
        check_eq("rst_lr", {l1 | r1}, 16'h0000);
        check_eq("rst_flags", {lv1, rv1, ss1, lk1, fe1}, 5'b0);
        model_reset();
        @(posedge clk);
        #1;
        ic_n = 1'b1;
        compare_all();
        send_frame(mk(10'h2FF, 3'd3), 1, 16, 0);
        send_frame(16'($urandom), 2, 16, 0);
        check_eq("post_rst_l", l1, 16'h03FC);
        check_eq("post_rst_locked", lk1, 1'b1);
        check_eq("post_rst_no_err", fe1, 1'b0);

        // random streams with enable gaps and occasional timing faults
        g_gap = 2;
        nxt = 1;
        for (int k = 0; k < 80; k++) begin
            ch = nxt;
            if ($urandom_range(7, 0) == 0) ch = int'($urandom_range(3, 0));
            n = 16;
            if ($urandom_range(7, 0) == 0) n = int'($urandom_range(20, 12));
            send_frame(16'($urandom), ch, n, $urandom_range(5, 0) == 0);
            if (ch == 1) nxt = 2;
            else if (ch == 2) nxt = 1;
        end
        send_frame(16'($urandom), 0, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
